// File: rtl/spm_host_if.sv
// Operand and product handshake bundle between a host client and spm_host.
interface spm_host_if #(
  parameter int unsigned BITS = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   in_a;
  logic [BITS-1:0]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic [2*BITS-1:0] out_p;

  modport master (
    output in_valid, in_a, in_x, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_x, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/spm_host.sv
// Host controller for the bit-serial multiplier: serializes the multiplicand
// LSB-first and reassembles the serial product into a parallel result.
module spm_host #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned Y_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  spm_host_if.slave       bus,
  output logic            busy,
  output logic            mult_rst_n,
  output logic            mult_x,
  output logic [BITS-1:0] mult_a,
  input  logic            mult_y
);
  localparam int unsigned PW = 2 * BITS;
  localparam int unsigned CW = $clog2(PW + Y_LAT + 1);
  localparam logic [CW-1:0] Y_C    = CW'(Y_LAT);
  localparam logic [CW-1:0] LAST_C = CW'(PW + Y_LAT - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] a_q, a_d;
  logic [PW-1:0]   x_sh_q, x_sh_d;
  logic [PW-1:0]   p_sh_q, p_sh_d;
  logic [PW-1:0]   out_p_q, out_p_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    x_sh_d      = x_sh_q;
    p_sh_d      = p_sh_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.in_a;
          x_sh_d     = {{BITS{1'b0}}, bus.in_x};
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        x_sh_d = x_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // Product bit k appears Y_LAT cycles after multiplicand bit k was driven.
        if (cnt_q >= Y_C) begin
          p_sh_d = {mult_y, p_sh_q[PW-1:1]};
        end
        if (cnt_q == LAST_C) begin
          out_p_d     = {mult_y, p_sh_q[PW-1:1]};
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      x_sh_q      <= '0;
      p_sh_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      x_sh_q      <= x_sh_d;
      p_sh_q      <= p_sh_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // x_sh is zero-extended, so it is already zero once past the multiplicand bits.
  assign mult_x        = (state_q == SHIFT) & x_sh_q[0];
  assign mult_a        = a_q;
  assign mult_rst_n    = ~rst & (state_q != CLEAR);
  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_spm_host.sv
// Bench for spm_host at BITS=8 (directed) and BITS=32 (random), each driving
// an arithmetic model of the serial multiplier.
module tb_spm_host;
  localparam int unsigned YL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- BITS=8 instance ----------------
  spm_host_if #(.BITS(8)) bus8 ();
  logic       busy8, mrn8, mx8, my8;
  logic [7:0] ma8;
  spm_host #(.BITS(8), .Y_LAT(YL)) u8 (
    .clk(clk), .rst(rst), .bus(bus8), .busy(busy8),
    .mult_rst_n(mrn8), .mult_x(mx8), .mult_a(ma8), .mult_y(my8)
  );

  // Product bit k depends only on multiplicand bits 0..k.
  int unsigned k8;
  logic [15:0] xacc8;
  always @(posedge clk) begin
    if (!mrn8) begin
      k8 = 0; xacc8 = '0; my8 <= 1'b0;
    end else if (k8 < 16) begin
      xacc8 = xacc8 | (16'(mx8) << k8);
      my8  <= ((16'(ma8) * xacc8) >> k8) & 16'd1;
      k8++;
    end else begin
      my8 <= 1'b0;
    end
  end

  // ---------------- BITS=32 instance ----------------
  spm_host_if #(.BITS(32)) bus32 ();
  logic        busy32, mrn32, mx32, my32;
  logic [31:0] ma32;
  spm_host #(.BITS(32), .Y_LAT(YL)) u32 (
    .clk(clk), .rst(rst), .bus(bus32), .busy(busy32),
    .mult_rst_n(mrn32), .mult_x(mx32), .mult_a(ma32), .mult_y(my32)
  );

  int unsigned k32;
  logic [63:0] xacc32;
  always @(posedge clk) begin
    if (!mrn32) begin
      k32 = 0; xacc32 = '0; my32 <= 1'b0;
    end else if (k32 < 64) begin
      xacc32 = xacc32 | (64'(mx32) << k32);
      my32  <= ((64'(ma32) * xacc32) >> k32) & 64'd1;
      k32++;
    end else begin
      my32 <= 1'b0;
    end
  end

  // Offers one operand pair, scrambles the inputs after acceptance, and
  // waits for the product; optionally stalls out_ready for hold cycles.
  task automatic run8(input logic [7:0] x, input logic [7:0] a, input int hold,
                      input bit chk_lat, input string tag);
    logic [15:0] exp;
    int k, lowc;
    exp = 16'(x) * 16'(a);
    bus8.out_ready = (hold == 0);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(bus8.in_ready), 64'd1);
    bus8.in_valid = 1'b1; bus8.in_x = x; bus8.in_a = a;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.in_x = 8'($urandom); bus8.in_a = 8'($urandom);
    check({tag, "_busy"}, {62'd0, busy8, bus8.in_ready}, 64'd2);
    k = 0; lowc = 0;
    while (!bus8.out_valid && k < 100) begin
      if (!mrn8) lowc++;
      @(negedge clk);
      k++;
    end
    if (chk_lat) begin
      check({tag, "_latency"}, 64'(k), 64'd18);
      check({tag, "_clr_cycles"}, 64'(lowc), 64'd1);
    end else if (k >= 100) begin
      check({tag, "_timeout"}, 64'(bus8.out_valid), 64'd1);
    end
    check({tag, "_p"}, 64'(bus8.out_p), 64'(exp));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check({tag, "_hold_v"}, {62'd0, bus8.out_valid, bus8.in_ready}, 64'd2);
        check({tag, "_hold_p"}, 64'(bus8.out_p), 64'(exp));
        bus8.in_valid = 1'($urandom);
        bus8.in_x = 8'($urandom); bus8.in_a = 8'($urandom);
        @(negedge clk);
      end
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_xfer"}, {62'd0, bus8.out_valid, bus8.in_ready}, 64'd1);
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] a);
    logic [63:0] exp;
    int k;
    exp = 64'(x) * 64'(a);
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.in_x = x; bus32.in_a = a;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.in_x = $urandom; bus32.in_a = $urandom;
    k = 0;
    while (!bus32.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("p32_timeout", 64'(bus32.out_valid), 64'd1);
    check("p32", bus32.out_p, exp);
    @(negedge clk);
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.in_x = '0; bus8.in_a = '0; bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_x = '0; bus32.in_a = '0; bus32.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_out_p", 64'(bus8.out_p), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_mult", {54'd0, mx8, ma8, mrn8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'd13, 8'd11, 0, 1'b1, "d13x11");
    check("d13x11_const", 64'(bus8.out_p), 64'h008F);
    run8(8'hFF, 8'hFF, 0, 1'b1, "dff");
    run8(8'h01, 8'h80, 0, 1'b1, "d01x80");
    run8(8'h00, 8'hA5, 0, 1'b0, "dx0");
    run8(8'hA5, 8'h00, 0, 1'b0, "da0");
    run8(8'd77, 8'd201, 10, 1'b0, "stall");
    run8(8'd9, 8'd7, 0, 1'b1, "after_stall");

    // Reset asserted while SHIFT is at cnt=5.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_x = 8'd200; bus8.in_a = 8'd3;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_mrn", 64'(mrn8), 64'd0);
    check("rst_mid_ov", 64'(bus8.out_valid), 64'd0);
    @(negedge clk);
    check("rst_mid_idle", {61'd0, busy8, bus8.in_ready, bus8.out_valid}, 64'd2);
    check("rst_mid_p", 64'(bus8.out_p), 64'd0);
    rst = 1'b0;
    run8(8'd200, 8'd3, 0, 1'b1, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x, a;
      x = $urandom; a = $urandom;
      if (i == 0) x = '1;
      if (i == 1) begin x = '1; a = '1; end
      if (i == 2) a = '0;
      run32(x, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
